// File: rtl/spi_reg_bank.sv
// SPI-slave register bank: frames of R/W bit, address and data on COPI,
// with write-back into a flat register file and serial read-back on CIPO.
module spi_reg_bank #(
  parameter int                ADDR_W    = 7,
  parameter int                DATA_W    = 8,
  parameter int                NUM_REGS  = 5,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                         SCLK,
  input  logic                         rst_n,
  input  logic                         nCS,
  input  logic                         COPI,
  output logic                         CIPO,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o,
  output logic                         addr_err
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_t;

  localparam int MAXW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CW   = $clog2(MAXW + 1);
  localparam int OW   = $clog2(DATA_W + 1);

  state_t              state_q, state_d, cur;
  logic [CW-1:0]       cnt_q;
  logic                rw_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W-1:0]   rd_data;
  logic                in_range;
  logic                wr_fire;
  logic                load_rd;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic                addr_err_w, addr_err_r;
  logic [DATA_W-1:0]   out_q;
  logic [OW-1:0]       ocnt_q;
  logic                oe_q;

  // The frame logic is held in IDLE while nCS is high; once nCS is low an
  // IDLE register is already the CMD phase, so edge 0 decodes the R/W bit.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cur     = (state_q == IDLE) ? CMD : state_q;
    state_d = cur;
    case (cur)
      CMD:     state_d = ADDR;
      ADDR:    if (cnt_q == CW'(ADDR_W - 1)) state_d = DATA;
      DATA:    if (cnt_q == CW'(DATA_W - 1)) state_d = DONE;
      default: state_d = cur;
    endcase
  end

  assign wdata    = DATA_W'({data_q, COPI});
  assign in_range = {1'b0, addr_q} < (ADDR_W + 1)'(NUM_REGS);
  assign wr_fire  = (cur == DATA) && (cnt_q == CW'(DATA_W - 1)) && rw_q;
  assign load_rd  = (state_q == DATA) && (cnt_q == '0) && !rw_q;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge SCLK or negedge rst_n or posedge nCS) begin
    if (!rst_n || nCS) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      case (cur)
        CMD: begin
          rw_q  <= COPI;
          cnt_q <= '0;
        end
        ADDR: begin
          addr_q <= ADDR_W'({addr_q, COPI});
          cnt_q  <= (state_d == ADDR) ? cnt_q + CW'(1) : '0;
        end
        DATA: begin
          data_q <= wdata;
          cnt_q  <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // NOTE: the bank is a set of flops with a defined reset value, not a RAM,
  // so every entry is cleared by rst_n (and only by rst_n).
  always_ff @(posedge SCLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
      addr_err_w <= 1'b0;
    end else if (wr_fire) begin
      if (!in_range) addr_err_w <= 1'b1;
      for (int i = 0; i < NUM_REGS; i++)
        if (addr_q == ADDR_W'(i)) regs[i] <= wdata;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (addr_q == ADDR_W'(i)) rd_data = regs[i];
  end

  // Read data launches on falling edges so the master sees it settled on rising ones.
  always_ff @(negedge SCLK or negedge rst_n or posedge nCS) begin
    if (!rst_n || nCS) begin
      out_q  <= '0;
      ocnt_q <= '0;
      oe_q   <= 1'b0;
    end else if (load_rd) begin
      out_q  <= rd_data;
      ocnt_q <= '0;
      oe_q   <= 1'b1;
    end else if (oe_q) begin
      if (ocnt_q == OW'(DATA_W - 1)) begin
        out_q <= '0;
        oe_q  <= 1'b0;
      end else begin
        out_q  <= out_q << 1;
        ocnt_q <= ocnt_q + OW'(1);
      end
    end
  end

  always_ff @(negedge SCLK or negedge rst_n) begin
    if (!rst_n)                   addr_err_r <= 1'b0;
    else if (load_rd && !in_range) addr_err_r <= 1'b1;
  end

  assign addr_err = addr_err_w | addr_err_r;
  assign cipo_oe  = oe_q;
  assign CIPO     = oe_q & out_q[DATA_W-1];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: register/flag checks inline, read-back
// bits checked by a CIPO monitor against a queue of expected bits.
module tb_spi_reg_bank;

  logic        SCLK = 1'b0;
  logic        rst_n;
  logic        nCS;
  logic        COPI;
  logic        CIPO;
  logic        cipo_oe;
  logic [39:0] regs_o;
  logic        addr_err;

  int n_vec = 0;
  int n_err = 0;
  logic exp_q[$];

  spi_reg_bank dut (
    .SCLK     (SCLK),
    .rst_n    (rst_n),
    .nCS      (nCS),
    .COPI     (COPI),
    .CIPO     (CIPO),
    .cipo_oe  (cipo_oe),
    .regs_o   (regs_o),
    .addr_err (addr_err)
  );

  always #5 SCLK = ~SCLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives n bits of v MSB first; each bit is set 2ns after a falling edge.
  task automatic send(input logic [31:0] v, input int n, input bit close, input bit nowait);
    for (int i = 0; i < n; i++) begin
      if (!(i == 0 && nowait)) begin
        @(negedge SCLK);
        #2;
      end
      nCS  = 1'b0;
      COPI = v[n-1-i];
    end
    if (close) begin
      @(negedge SCLK);
      #2;
      nCS  = 1'b1;
      COPI = 1'b0;
    end
  endtask

  task automatic expect_read(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) exp_q.push_back(d[i]);
  endtask

  task automatic read_frame(input logic [6:0] a, input logic [7:0] d);
    expect_read(d);
    send({16'h0, 1'b0, a, 8'h00}, 16, 1'b1, 1'b0);
    check("rd_drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: samples just before each rising edge, where the master would.
  initial begin
    forever begin
      @(negedge SCLK);
      #4;
      if (cipo_oe) begin
        if (exp_q.size() == 0) begin
          check("cipo_unexpected_oe", 64'(cipo_oe), 64'd0);
        end else begin
          logic e;
          e = exp_q.pop_front();
          check("cipo_bit", 64'(CIPO), 64'(e));
        end
      end else begin
        check("cipo_idle_zero", 64'(CIPO), 64'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    nCS   = 1'b1;
    COPI  = 1'b0;
    repeat (2) @(negedge SCLK);
    #2;
    check("rst_regs",  regs_o,   40'h0);
    check("rst_err",   addr_err, 1'b0);
    check("rst_oe",    cipo_oe,  1'b0);
    check("rst_cipo",  CIPO,     1'b0);
    rst_n = 1'b1;

    send({16'h0, 1'b1, 7'd2, 8'hA5}, 16, 1'b1, 1'b0);
    check("wr_a5", regs_o, 40'h00_00_A5_00_00);

    read_frame(7'd2, 8'hA5);
    check("rd_a5_regs", regs_o, 40'h00_00_A5_00_00);

    send({16'h0, 1'b1, 7'd1, 8'h5A} >> 4, 12, 1'b1, 1'b0);
    check("abort_regs", regs_o, 40'h00_00_A5_00_00);
    check("abort_err",  addr_err, 1'b0);
    send({16'h0, 1'b1, 7'd6, 8'h00} >> 4, 12, 1'b1, 1'b0);
    check("abort_bad_err", addr_err, 1'b0);

    send({16'h0, 1'b1, 7'd1, 8'h5A}, 16, 1'b1, 1'b0);
    check("wr_5a", regs_o, 40'h00_00_A5_5A_00);
    read_frame(7'd1, 8'h5A);

    // Back-to-back frames with nCS high between two SCLK edges.
    send({16'h0, 1'b1, 7'd0, 8'h11}, 16, 1'b0, 1'b0);
    @(negedge SCLK);
    #1;
    nCS = 1'b1;
    #1;
    send({16'h0, 1'b1, 7'd3, 8'h22}, 16, 1'b1, 1'b1);
    check("b2b_regs", regs_o, 40'h00_22_A5_5A_11);

    send({16'h0, 1'b1, 7'd5, 8'hFF}, 16, 1'b1, 1'b0);
    check("bad_wr_regs", regs_o, 40'h00_22_A5_5A_11);
    check("bad_wr_err",  addr_err, 1'b1);
    read_frame(7'd5, 8'h00);

    send({16'h0, 1'b1, 7'd4, 8'h3C}, 16, 1'b1, 1'b0);
    check("wr_3c", regs_o, 40'h3C_22_A5_5A_11);

    // Reset asserted in the middle of a frame.
    send({16'h0, 1'b1, 7'd2, 8'hC3} >> 6, 10, 1'b0, 1'b0);
    @(negedge SCLK);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_regs", regs_o,   40'h0);
    check("midrst_err",  addr_err, 1'b0);
    check("midrst_oe",   cipo_oe,  1'b0);
    nCS = 1'b1;
    @(negedge SCLK);
    #2;
    rst_n = 1'b1;
    send({16'h0, 1'b1, 7'd0, 8'h77}, 16, 1'b1, 1'b0);
    check("post_rst_wr", regs_o, 40'h00_00_00_00_77);

    read_frame(7'd7, 8'h00);
    check("bad_rd_err", addr_err, 1'b1);

    send({12'h0, 1'b1, 7'd3, 8'h81, 4'hF}, 20, 1'b1, 1'b0);
    check("long_wr_regs", regs_o, 40'h00_81_00_00_77);
    read_frame(7'd3, 8'h81);
    check("final_regs", regs_o, 40'h00_81_00_00_77);

    repeat (2) @(negedge SCLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_reg_bank.md
SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, address field width in bits.
REQ-002 SHALL have parameter DATA_W, default 8, register width and data field width in bits.
REQ-003 SHALL have parameter NUM_REGS, default 5, number of implemented registers (1..2^ADDR_W).
REQ-004 SHALL have parameter RESET_VAL, default 0, DATA_W-bit reset value of every register.
REQ-005 SHALL have port SCLK  input  1  clock (SPI clock); all sampling is on the rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port nCS  input  1  chip select, active-low, frame delimiter.
REQ-008 SHALL have port COPI  input  1  serial data in, MSB first.
REQ-009 SHALL have port CIPO  output  1  serial read data out, MSB first.
REQ-010 SHALL have port cipo_oe  output  1  high while CIPO carries valid read data.
REQ-011 SHALL have port regs_o  output  NUM_REGS*DATA_W  flattened registers, register i at bits [i*DATA_W +: DATA_W].
REQ-012 SHALL have port addr_err  output  1  sticky flag: a frame addressed a register >= NUM_REGS.

Function
REQ-013 SHALL frame as: bit 0 = R/W (1 write, 0 read), bits 1..ADDR_W = address MSB first, next DATA_W bits = data MSB first; frame length F = 1+ADDR_W+DATA_W.
REQ-014 SHALL sample bit k on the k-th rising SCLK edge (k from 0) after nCS falls.
REQ-015 SHALL implement states IDLE, CMD, ADDR, DATA, DONE; IDLE->CMD on nCS low, CMD->ADDR after bit 0, ADDR->DATA after address LSB, DATA->DONE after data LSB.
REQ-016 SHALL return the state machine, bit counter and shift registers asynchronously to IDLE/zero whenever nCS is high; registers and addr_err are NOT affected by nCS.
REQ-017 SHALL, on a write frame, update register[addr] with the assembled data on the same rising edge that samples the data LSB (edge F-1); regs_o reflects the new value immediately after that edge.
REQ-018 SHALL ignore a write when addr >= NUM_REGS (no register changes) and set addr_err on edge F-1.
REQ-019 SHALL, on a read frame, load register[addr] (0 if addr >= NUM_REGS) into the output shift register on the falling SCLK edge after the address LSB is sampled, and drive its MSB on CIPO.
REQ-020 SHALL shift CIPO on each subsequent falling SCLK edge, so the master samples data bit DATA_W-1-j on rising edge 1+ADDR_W+j.
REQ-021 SHALL set addr_err on a read frame with addr >= NUM_REGS, at the falling edge in REQ-019.
REQ-022 SHALL hold cipo_oe high only from the REQ-019 load until nCS rises or the last data bit has been held for one full SCLK period; CIPO SHALL be 0 whenever cipo_oe is low.
REQ-023 SHALL ignore all bits after bit F-1 (DONE) until nCS rises; no second write occurs.
REQ-024 SHALL discard a frame terminated by nCS high before edge F-1: no register update, addr_err unchanged.
REQ-025 SHALL never modify registers during a read frame.
REQ-026 SHALL accept back-to-back frames with nCS high for any duration, including zero SCLK edges.

Reset
REQ-027 SHALL, while rst_n is low, force all registers to RESET_VAL, addr_err=0, CIPO=0, cipo_oe=0, state IDLE, counters and shift registers 0.
REQ-028 SHALL abort any frame in progress when rst_n asserts; after rst_n and nCS deassert, the next frame starts at bit 0.

Verification
REQ-029 SHALL cover: write frame 1,0000010,0xA5 -> regs_o[23:16]=0xA5 after edge 15, other registers 0.
REQ-030 SHALL cover: after REQ-029, read frame 0,0000010 -> CIPO=1,0,1,0,0,1,0,1 at rising edges 8..15, cipo_oe=1, registers unchanged.
REQ-031 SHALL cover: write frame 1,0000101,0xFF -> no register change, addr_err=1; read of address 5 -> CIPO all 0.
REQ-032 SHALL cover: write frame to address 1 with nCS raised after 12 edges -> regs_o[15:8] unchanged, addr_err unchanged; next full frame writes correctly.
REQ-033 SHALL cover: rst_n pulsed low mid-frame after writing 0x3C to address 4 -> all registers 0, addr_err 0, following frame decoded from bit 0.
REQ-034 SHALL cover: 20 SCLK edges in a write frame to address 3 with data 0x81 then extra bits -> register 3 = 0x81, written once.
